// File: rtl/seq_8085_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_8085_multi : multi-cycle 8085-style instruction sequencer with retire   |
// |                  counter. Optional macro WAIT_STATE_EN: MEM waits mem_ready.|
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module seq_8085_multi #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       op_class,
  input  logic             cond_met,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             Accwrite,
  output logic             read,
  output logic             write,
  output logic             cywrite,
  output logic             zwrite,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    BAD    = 3'd7
  } state_t;

  localparam logic [2:0] OP_ALU_R = 3'd0;
  localparam logic [2:0] OP_ALU_I = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JCC   = 3'd5;
  localparam logic [2:0] OP_HLT   = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             mem_done;

`ifdef WAIT_STATE_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    Accwrite = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    cywrite  = 1'b0;
    zwrite   = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        read    = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (op_class == OP_HLT) begin
          state_d = HALT;
          retire  = 1'b1;
        end else if (op_class == OP_NOP) begin
          retire = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_class)
          OP_ALU_R, OP_ALU_I: begin
            cywrite = 1'b1;
            zwrite  = 1'b1;
            state_d = WB;
          end
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_JMP: begin
            pcwrite = 1'b1;
            retire  = 1'b1;
          end
          OP_JCC: begin
            pcwrite = cond_met;
            retire  = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      MEM: begin
        // The strobe stays up for every wait cycle, not just the completing one.
        if (op_class == OP_LOAD) begin
          read = 1'b1;
          if (mem_done) state_d = WB;
        end else begin
          write  = (op_class == OP_STORE);
          retire = mem_done;
        end
      end
      WB: begin
        Accwrite = (op_class == OP_ALU_R) || (op_class == OP_ALU_I) || (op_class == OP_LOAD);
        retire   = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    // Retire boundary: HLT parks in HALT, everything else follows run.
    if (retire && (state_d != HALT)) state_d = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_8085_multi.sv
`default_nettype none
// Testbench for seq_8085_multi: directed and randomized instruction streams checked
// against a per-instruction phase list and strobe-count model.
module tb_seq_8085_multi;

  localparam int CW = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6;
  localparam logic [2:0] C_ALU_R = 3'd0, C_ALU_I = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3;
  localparam logic [2:0] C_JMP   = 3'd4, C_JCC   = 3'd5, C_HLT  = 3'd6, C_NOP   = 3'd7;

  logic          clk = 1'b0;
  logic          rst, run, cond_met, mem_ready;
  logic [2:0]    op_class;
  logic          pcwrite, irwrite, regwrite, Accwrite, read, write, cywrite, zwrite;
  logic          halted;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic [7:0]    strb;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  seq_8085_multi #(.CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .op_class (op_class),
    .cond_met (cond_met),
    .mem_ready(mem_ready),
    .pcwrite  (pcwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .Accwrite (Accwrite),
    .read     (read),
    .write    (write),
    .cywrite  (cywrite),
    .zwrite   (zwrite),
    .halted   (halted),
    .state    (state),
    .retired  (retired)
  );

  assign strb = {pcwrite, irwrite, regwrite, Accwrite, read, write, cywrite, zwrite};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Wait in IDLE with run low, then raise run; returns one cycle later (DUT in FETCH).
  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      run       = 1'b0;
      op_class  = 3'($urandom_range(0, 7));
      cond_met  = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("idle_state", state, S_IDLE);
      chk("idle_strobes", strb, 8'h00);
      chk("idle_retired", retired, exp_ret[CW-1:0]);
      @(posedge clk); #1;
    end
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  // One instruction from FETCH entry. run_mid: 0/1 fixed, 2 random before retire.
  task automatic do_instr(input logic [2:0] cls, input logic cnd, input int waits,
                          input int run_mid, input logic run_after, input int abort_at);
    logic [2:0] ph[$];
    int eff_w;
    int mem_i = 0;
    int rd_n = 0, ir_n = 0, pc_n = 0, wr_n = 0, acc_n = 0, cy_n = 0, z_n = 0, rg_n = 0;
    bit is_alu, is_mem;
    logic [2:0] nxt;
`ifdef WAIT_STATE_EN
    eff_w = waits;
`else
    eff_w = 0;
`endif
    is_alu = (cls == C_ALU_R) || (cls == C_ALU_I);
    is_mem = (cls == C_LOAD) || (cls == C_STORE);
    ph = {S_FETCH, S_DECODE};
    if (cls != C_HLT && cls != C_NOP) ph.push_back(S_EXEC);
    if (is_mem) repeat (eff_w + 1) ph.push_back(S_MEM);
    if (is_alu || cls == C_LOAD) ph.push_back(S_WB);

    for (int i = 0; i < ph.size(); i++) begin
      if (ph[i] == S_FETCH) begin
        op_class = 3'($urandom_range(0, 7));
        cond_met = 1'($urandom_range(0, 1));
      end else begin
        op_class = cls;
        cond_met = cnd;
      end
      if (ph[i] == S_MEM) begin
        mem_ready = (mem_i < waits) ? 1'b0 : 1'b1;
        mem_i++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (i == ph.size() - 1) run = run_after;
      else run = (run_mid > 1) ? 1'($urandom_range(0, 1)) : 1'(run_mid);
      #1;
      chk("phase_state", state, ph[i]);
      rd_n += read;     ir_n += irwrite; pc_n += pcwrite; wr_n += write;
      acc_n += Accwrite; cy_n += cywrite; z_n += zwrite;  rg_n += regwrite;
      if (i == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_state", state, S_IDLE);
        chk("rst_strobes", strb, 8'h00);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 1'b0);
        exp_ret = 0;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("post_rst_state", state, S_IDLE);
        return;
      end
      @(posedge clk); #1;
    end

    chk("cnt_read", rd_n, 1 + ((cls == C_LOAD) ? eff_w + 1 : 0));
    chk("cnt_irwrite", ir_n, 1);
    chk("cnt_pcwrite", pc_n, 1 + ((cls == C_JMP) ? 1 : 0) + ((cls == C_JCC && cnd) ? 1 : 0));
    chk("cnt_write", wr_n, (cls == C_STORE) ? eff_w + 1 : 0);
    chk("cnt_accwrite", acc_n, (is_alu || cls == C_LOAD) ? 1 : 0);
    chk("cnt_cywrite", cy_n, is_alu ? 1 : 0);
    chk("cnt_zwrite", z_n, is_alu ? 1 : 0);
    chk("cnt_regwrite", rg_n, 0);
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk("retired", retired, exp_ret[CW-1:0]);
    nxt = (cls == C_HLT) ? S_HALT : (run_after ? S_FETCH : S_IDLE);
    chk("next_state", state, nxt);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rc;
    logic       ra;
    rst = 1'b1; run = 1'b0; op_class = 3'd0; cond_met = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset_state", state, S_IDLE);
    chk("reset_retired", retired, 0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_strobes", strb, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    idle_wait(2);

    // ALU-reg, NOP, JMP back to back
    do_instr(C_ALU_R, 1'b0, 0, 1, 1'b1, -1);
    do_instr(C_NOP,   1'b0, 0, 1, 1'b1, -1);
    do_instr(C_JMP,   1'b0, 0, 1, 1'b1, -1);
    chk("three_retired", retired, 3);

    do_instr(C_JCC,   1'b0, 0, 1, 1'b1, -1);
    do_instr(C_JCC,   1'b1, 0, 1, 1'b1, -1);
    do_instr(C_STORE, 1'b0, 3, 1, 1'b1, -1);
    do_instr(C_LOAD,  1'b0, 2, 1, 1'b1, -1);
    do_instr(C_ALU_I, 1'b1, 0, 0, 1'b0, -1);
    idle_wait(2);

    for (int k = 0; k < 40; k++) begin
      rc = 3'($urandom_range(0, 6));
      if (rc == C_HLT) rc = C_NOP;
      ra = 1'($urandom_range(0, 1));
      do_instr(rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 2, ra, -1);
      if (!ra) idle_wait(1);
    end

    // Reset during the MEM cycle of a LOAD
    do_instr(C_LOAD, 1'b0, 0, 1, 1'b1, 3);
    idle_wait(3);

    // Counter wrap, then HLT
    for (int k = 0; k < 17; k++) do_instr(C_NOP, 1'b0, 0, 1, 1'b1, -1);
    do_instr(C_HLT, 1'b0, 0, 1, 1'b1, -1);
    chk("halt_retired", retired, 2);
    for (int k = 0; k < 4; k++) begin
      run       = 1'($urandom_range(0, 1));
      op_class  = 3'($urandom_range(0, 7));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("halt_state", state, S_HALT);
      chk("halt_flag", halted, 1'b1);
      chk("halt_strobes", strb, 8'h00);
      chk("halt_hold_retired", retired, 2);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("halt_exit_state", state, S_IDLE);
    chk("halt_exit_flag", halted, 1'b0);
    chk("halt_exit_retired", retired, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_8085_multi.md
SEQ_8085_MULTI -- requirements
Module: seq_8085_multi

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 The block SHALL have these ports, one per line, clock and reset first:
  clk  input  1  single system clock; all state updates on its rising edge
  rst  input  1  asynchronous, active-high reset
  run  input  1  level; 1 permits instruction sequencing
  op_class  input  3  decoded class of the held instruction: 0 ALU-reg, 1 ALU-imm, 2 LOAD, 3 STORE, 4 JMP, 5 JCC, 6 HLT, 7 NOP
  cond_met  input  1  condition result from the z/cy flags for JCC
  mem_ready  input  1  data memory completion (used only with WAIT_STATE_EN)
  pcwrite, irwrite, regwrite, Accwrite, read, write, cywrite, zwrite  output  1 each  datapath strobes
  halted  output  1  1 while in HALT
  state  output  3  current state encoding
  retired  output  CNT_W  count of completed instructions

Function
REQ-003 States SHALL be encoded as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; value 7 SHALL be unreachable and SHALL recover to IDLE on the next edge.
REQ-004 The state register SHALL be registered; strobes SHALL be combinational from state and op_class, and every strobe not listed for a state SHALL be 0.
REQ-005 IDLE: no strobes; run=1 -> FETCH, else stay.
REQ-006 FETCH: read=1, irwrite=1, pcwrite=1 (PC+1); -> DECODE unconditionally.
REQ-007 DECODE: no strobes; HLT -> HALT; NOP -> retire; all other classes -> EXEC.
REQ-008 EXEC: ALU-reg/ALU-imm assert cywrite=1, zwrite=1 -> WB; LOAD/STORE -> MEM with no strobes; JMP asserts pcwrite=1 -> retire; JCC asserts pcwrite=cond_met -> retire.
REQ-009 MEM: LOAD asserts read=1 -> WB; STORE asserts write=1 -> retire.
REQ-010 WB: ALU-reg/ALU-imm/LOAD assert Accwrite=1 -> retire; regwrite SHALL be asserted only in WB and only for ALU-reg with the register-destination bit absent, i.e. held 0 in this revision.
REQ-011 Retire SHALL mean: retired increments by 1 on that edge, and the next state is FETCH if run=1, else IDLE.
REQ-012 Latencies, clock edges from FETCH entry to the next FETCH, with run=1: NOP 2; JMP/JCC 3; ALU 4; STORE 4; LOAD 5 (no wait states).
REQ-013 run falling mid-instruction SHALL NOT abort; the instruction completes and the block parks in IDLE at the retire boundary.
REQ-014 HALT: halted=1, no strobes, retired increments once on entry; it is left only by rst.
REQ-015 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-016 op_class and cond_met SHALL be sampled only in DECODE/EXEC/MEM/WB; their values in IDLE/FETCH SHALL be ignored.

Reset
REQ-017 rst=1 SHALL immediately force state=IDLE, retired=0, halted=0, and all strobes=0, independent of clk.
REQ-018 rst asserted mid-instruction SHALL abandon it without a retire increment; after release the block waits in IDLE for run.

Configuration
REQ-019 Macro WAIT_STATE_EN: when defined, MEM SHALL hold with its read/write strobe asserted while mem_ready=0 and advance on the edge where mem_ready=1; when undefined, mem_ready SHALL be ignored and MEM SHALL last exactly one cycle.

Verification
REQ-020 rst pulse mid-LOAD in MEM -> state=0, all strobes 0 asynchronously, retired=0, no write or Accwrite afterwards.
REQ-021 run=1 with classes ALU-reg, NOP, JMP -> state sequence 1,2,3,5,1,2,1,2,3,1; retired=3 after the 10th edge.
REQ-022 JCC with cond_met=0, then with cond_met=1 -> pcwrite=0 in EXEC in the first case and pcwrite=1 in EXEC in the second; 3 cycles each.
REQ-023 WAIT_STATE_EN defined, STORE with mem_ready low for 3 cycles -> write=1 for 4 consecutive cycles, one retire; with the macro undefined -> write=1 for exactly 1 cycle.
REQ-024 run dropped during EXEC of an ALU instruction -> WB with Accwrite=1 completes, then state=0 and retired increments by 1.
REQ-025 CNT_W=4: retire 17 NOPs then HLT -> retired=2, halted=1 and held until rst.
